// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared EX-stage types and constants used by the result skid
//            buffer, its handshake interface and the testbench.
// Contents : DATA_W / REG_W       - ALU result and register index widths
//            ex_res_t             - {result, rd, wb_en} payload of one beat
//            skid_state_t         - buffer occupancy state (EMPTY/ONE/FULL)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
    } ex_res_t;

    // Encoding equals occupancy so the state register doubles as the count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ex_result_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_result_skid_buf_if
// Purpose  : Valid/ready stream carrying one EX result beat per transfer.
// Signals  : valid   - producer presents a beat
//            ready   - consumer accepts the beat this cycle
//            result  - ALU result (DATA_W)
//            rd      - destination register index (REG_W)
//            wb_en   - beat is to be written back
// Modports : master - producer side (drives valid/payload, samples ready)
//            slave  - consumer side (samples valid/payload, drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface ex_result_skid_buf_if;

    logic                       valid;
    logic                       ready;
    logic [cpu_pkg::DATA_W-1:0] result;
    logic [cpu_pkg::REG_W-1:0]  rd;
    logic                       wb_en;

    modport master (
        output valid,
        output result,
        output rd,
        output wb_en,
        input  ready
    );

    modport slave (
        input  valid,
        input  result,
        input  rd,
        input  wb_en,
        output ready
    );

endinterface : ex_result_skid_buf_if
`default_nettype wire

// File: rtl/ex_result_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : ex_result_skid_buf
// Purpose  : Registered output stage behind the EX result mux. Holds up to two
//            {result, rd, wb_en} beats in a strict-FIFO skid buffer and hands
//            them to MEM/WB over a valid/ready handshake. Supports a
//            synchronous flush and an optional forwarding tap.
// Ports    : clk       - pipeline clock, all state on the rising edge
//            reset     - asynchronous, active-low reset
//            flush     - discard all buffered entries (wins over push/pop)
//            in_if     - slave stream from EX (in_ready = count != 2)
//            out_if    - master stream to MEM/WB (head entry)
//            count     - occupancy 0..2
//            fwd_valid - forwarding candidate valid
//            fwd_rd    - forwarding destination register
//            fwd_data  - forwarding value
// Config   : EX_FWD_BYPASS_EN defined   -> fwd_* show the youngest buffered
//                                          entry that will be written back
//            EX_FWD_BYPASS_EN undefined -> fwd_* tied to zero
// Revision : 1.0 - initial release
// ============================================================================
module ex_result_skid_buf
    import cpu_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                flush,
    ex_result_skid_buf_if.slave      in_if,
    ex_result_skid_buf_if.master     out_if,
    output      logic [1:0]          count,
    output      logic                fwd_valid,
    output      logic [REG_W-1:0]    fwd_rd,
    output      logic [DATA_W-1:0]   fwd_data
);

    skid_state_t state_q;
    ex_res_t     head_q;
    ex_res_t     tail_q;

    logic        w_push;
    logic        w_pop;
    ex_res_t     w_in_beat;

    // r0 is hard-wired zero, so a write to it is never requested downstream.
    function automatic ex_res_t sanitize_beat(
        input logic [DATA_W-1:0] result,
        input logic [REG_W-1:0]  rd,
        input logic              wb_en
    );
        ex_res_t beat;
        beat.result = result;
        beat.rd     = rd;
        beat.wb_en  = wb_en & (rd != '0);
        return beat;
    endfunction

    // Youngest buffered entry that will write back: tail when both slots are
    // occupied and the tail writes, otherwise the head if it writes.
    function automatic ex_res_t fwd_select(
        input skid_state_t st,
        input ex_res_t     head,
        input ex_res_t     tail
    );
        ex_res_t sel;
        sel = '0;
        if ((st == FULL) && tail.wb_en) begin
            sel = tail;
        end else if ((st != EMPTY) && head.wb_en) begin
            sel = head;
        end
        return sel;
    endfunction

    // Handshake flags come from registered state only: no input-to-output path.
    assign in_if.ready   = (state_q != FULL);
    assign out_if.valid  = (state_q != EMPTY);
    assign out_if.result = head_q.result;
    assign out_if.rd     = head_q.rd;
    assign out_if.wb_en  = head_q.wb_en;
    assign count         = state_q;

    assign w_push    = in_if.valid & in_if.ready;
    assign w_pop     = out_if.valid & out_if.ready;
    assign w_in_beat = sanitize_beat(in_if.result, in_if.rd, in_if.wb_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            // Entries are zeroed as well so out_wb_en drops with the flush.
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_push) begin
                        head_q  <= w_in_beat;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            tail_q  <= w_in_beat;
                            state_q <= FULL;
                        end
                        2'b01: begin
                            state_q <= EMPTY;
                        end
                        2'b11: begin
                            // Head leaves while the new beat takes its place.
                            head_q  <= w_in_beat;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (w_pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

`ifdef EX_FWD_BYPASS_EN
    ex_res_t w_fwd_sel;

    assign w_fwd_sel = fwd_select(state_q, head_q, tail_q);
    assign fwd_valid = w_fwd_sel.wb_en;
    assign fwd_rd    = w_fwd_sel.rd;
    assign fwd_data  = w_fwd_sel.result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule : ex_result_skid_buf
`default_nettype wire

// File: tb/tb_ex_result_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_result_skid_buf
// Purpose  : Self-checking bench for ex_result_skid_buf: directed vector table,
//            hand-written corner sequences (forwarding, async reset while
//            full) and randomized traffic against a queue-based model.
// Config   : honours EX_FWD_BYPASS_EN for the forwarding expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_result_skid_buf;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    logic [1:0]        count;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    ex_result_skid_buf_if in_if();
    ex_result_skid_buf_if out_if();

    always #5 clk = ~clk;

    ex_result_skid_buf dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_if     (in_if),
        .out_if    (out_if),
        .count     (count),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    int n_total = 0;
    int n_pass  = 0;

    ex_res_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic v, input logic [31:0] d,
                         input logic [4:0] rd, input logic wb, input logic ord);
        flush         = fl;
        in_if.valid   = v;
        in_if.result  = d;
        in_if.rd      = rd;
        in_if.wb_en   = wb;
        out_if.ready  = ord;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of at most two beats; flush empties it.
    task automatic model_step(input logic fl, input logic v, input logic [31:0] d,
                              input logic [4:0] rd, input logic wb, input logic ord);
        ex_res_t beat;
        bit push, pop;
        push = v && (model_q.size() < 2);
        pop  = ord && (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                beat.result = d;
                beat.rd     = rd;
                beat.wb_en  = wb && (rd != 0);
                model_q.push_back(beat);
            end
        end
    endtask

    task automatic check_vs_model(input string tag);
        logic              e_fv;
        logic [REG_W-1:0]  e_frd;
        logic [DATA_W-1:0] e_fd;
        check({tag, ".count"}, count, model_q.size());
        check({tag, ".in_ready"}, in_if.ready, model_q.size() < 2);
        check({tag, ".out_valid"}, out_if.valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            check({tag, ".out_result"}, out_if.result, model_q[0].result);
            check({tag, ".out_rd"}, out_if.rd, model_q[0].rd);
            check({tag, ".out_wb_en"}, out_if.wb_en, model_q[0].wb_en);
        end
        e_fv = 1'b0; e_frd = '0; e_fd = '0;
`ifdef EX_FWD_BYPASS_EN
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].wb_en && !e_fv) begin
                e_fv = 1'b1; e_frd = model_q[i].rd; e_fd = model_q[i].result;
            end
        end
`endif
        check({tag, ".fwd_valid"}, fwd_valid, e_fv);
        check({tag, ".fwd_rd"}, fwd_rd, e_frd);
        check({tag, ".fwd_data"}, fwd_data, e_fd);
    endtask

    // mode: 0 = handshake/count only, 1 = also head payload, 2 = also wb_en only
    typedef struct {
        logic        fl, v;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        wb, ord;
        logic [1:0]  e_cnt;
        logic        e_rdy, e_val;
        int          mode;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_wb;
    } vec_t;

    function automatic vec_t mk(logic fl, logic v, logic [31:0] d, logic [4:0] rd, logic wb,
                                logic ord, logic [1:0] e_cnt, logic e_rdy, logic e_val,
                                int mode, logic [31:0] e_res, logic [4:0] e_rd, logic e_wb);
        vec_t t;
        t.fl = fl; t.v = v; t.d = d; t.rd = rd; t.wb = wb; t.ord = ord;
        t.e_cnt = e_cnt; t.e_rdy = e_rdy; t.e_val = e_val; t.mode = mode;
        t.e_res = e_res; t.e_rd = e_rd; t.e_wb = e_wb;
        return t;
    endfunction

    vec_t vecs[14];

    initial begin
        logic              fl, v, wb, ord;
        logic [31:0]       d;
        logic [4:0]        rd;
        logic              e_fv;
        logic [REG_W-1:0]  e_frd;
        logic [DATA_W-1:0] e_fd;

        //             fl v  data          rd wb ord cnt rdy val mode res           rd wb
        vecs[0]  = mk(0, 1, 32'h0000_00FF, 3, 1, 1,  1,  1,  1,  1, 32'h0000_00FF, 3, 1);
        vecs[1]  = mk(0, 0, 32'h0,         0, 0, 1,  0,  1,  0,  0, 32'h0,         0, 0);
        vecs[2]  = mk(0, 1, 32'h11,        1, 1, 0,  1,  1,  1,  1, 32'h11,        1, 1);
        vecs[3]  = mk(0, 1, 32'h22,        2, 1, 0,  2,  0,  1,  1, 32'h11,        1, 1);
        vecs[4]  = mk(0, 1, 32'h99,        9, 1, 0,  2,  0,  1,  1, 32'h11,        1, 1);
        vecs[5]  = mk(0, 0, 32'h0,         0, 0, 1,  1,  1,  1,  1, 32'h22,        2, 1);
        vecs[6]  = mk(0, 0, 32'h0,         0, 0, 1,  0,  1,  0,  0, 32'h0,         0, 0);
        vecs[7]  = mk(0, 1, 32'h11,        1, 1, 0,  1,  1,  1,  1, 32'h11,        1, 1);
        vecs[8]  = mk(0, 1, 32'h33,        6, 1, 1,  1,  1,  1,  1, 32'h33,        6, 1);
        vecs[9]  = mk(0, 1, 32'h44,        7, 1, 0,  2,  0,  1,  1, 32'h33,        6, 1);
        vecs[10] = mk(1, 1, 32'h55,        8, 1, 1,  0,  1,  0,  2, 32'h0,         0, 0);
        vecs[11] = mk(0, 0, 32'h0,         0, 0, 0,  0,  1,  0,  2, 32'h0,         0, 0);
        vecs[12] = mk(0, 1, 32'h77,        0, 1, 0,  1,  1,  1,  1, 32'h77,        0, 0);
        vecs[13] = mk(0, 0, 32'h0,         0, 0, 1,  0,  1,  0,  0, 32'h0,         0, 0);

        drive(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) tick();
        reset = 1'b1;
        check("rst.count", count, 0);
        check("rst.in_ready", in_if.ready, 1);
        check("rst.out_valid", out_if.valid, 0);
        check("rst.out_result", out_if.result, 0);
        check("rst.out_rd", out_if.rd, 0);
        check("rst.out_wb_en", out_if.wb_en, 0);
        check("rst.fwd_valid", fwd_valid, 0);
        check("rst.fwd_rd", fwd_rd, 0);
        check("rst.fwd_data", fwd_data, 0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].wb, vecs[i].ord);
            tick();
            check($sformatf("vec%0d.count", i), count, vecs[i].e_cnt);
            check($sformatf("vec%0d.in_ready", i), in_if.ready, vecs[i].e_rdy);
            check($sformatf("vec%0d.out_valid", i), out_if.valid, vecs[i].e_val);
            if (vecs[i].mode == 1) begin
                check($sformatf("vec%0d.out_result", i), out_if.result, vecs[i].e_res);
                check($sformatf("vec%0d.out_rd", i), out_if.rd, vecs[i].e_rd);
            end
            if (vecs[i].mode != 0)
                check($sformatf("vec%0d.out_wb_en", i), out_if.wb_en, vecs[i].e_wb);
        end

        // Forwarding: FULL with both entries writing -> tail is youngest
        drive(0, 1, 32'hAA, 4, 1, 0); tick();
        drive(0, 1, 32'hBB, 5, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        check("fwd_full.count", count, 2);
`ifdef EX_FWD_BYPASS_EN
        e_fv = 1; e_frd = 5; e_fd = 32'hBB;
`else
        e_fv = 0; e_frd = 0; e_fd = 0;
`endif
        check("fwd_full.fwd_valid", fwd_valid, e_fv);
        check("fwd_full.fwd_rd", fwd_rd, e_frd);
        check("fwd_full.fwd_data", fwd_data, e_fd);

        // Forwarding: tail targets r0 (no write) -> head is youngest writer
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'hCC, 4, 1, 0); tick();
        drive(0, 1, 32'hDD, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        check("fwd_r0.count", count, 2);
`ifdef EX_FWD_BYPASS_EN
        e_fv = 1; e_frd = 4; e_fd = 32'hCC;
`else
        e_fv = 0; e_frd = 0; e_fd = 0;
`endif
        check("fwd_r0.fwd_valid", fwd_valid, e_fv);
        check("fwd_r0.fwd_rd", fwd_rd, e_frd);
        check("fwd_r0.fwd_data", fwd_data, e_fd);

        // Async reset while FULL clears immediately, before any clock edge
        #2 reset = 1'b0;
        #1;
        check("arst.count", count, 0);
        check("arst.in_ready", in_if.ready, 1);
        check("arst.out_valid", out_if.valid, 0);
        check("arst.out_result", out_if.result, 0);
        check("arst.fwd_valid", fwd_valid, 0);
        tick();
        reset = 1'b1;
        tick();
        check("arst_rel.count", count, 0);

        // Randomized traffic against the queue model
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            check_vs_model($sformatf("rnd%0d", c));
            fl  = ($urandom_range(0, 15) == 0);
            v   = $urandom_range(0, 1);
            ord = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 1) : 1'b0;
            d   = $urandom;
            rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb  = $urandom_range(0, 1);
            drive(fl, v, d, rd, wb, ord);
            model_step(fl, v, d, rd, wb, ord);
            tick();
        end
        check_vs_model("rnd_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ex_result_skid_buf
`default_nettype wire
